// File: rtl/imm_gen_stage_if.sv
// rtl/imm_gen_stage_if.sv - valid/ready bundle between decode, the immediate stage and execute
interface imm_gen_stage_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_inst;
  logic [3:0]       in_sel;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_imm;
  logic [TAG_W-1:0] out_tag;
  logic             out_err;

  modport master (
    output in_valid, in_inst, in_sel, in_tag, out_ready,
    input  in_ready, out_valid, out_imm, out_tag, out_err
  );

  modport slave (
    input  in_valid, in_inst, in_sel, in_tag, out_ready,
    output in_ready, out_valid, out_imm, out_tag, out_err
  );
endinterface

// File: rtl/imm_gen_stage.sv
// rtl/imm_gen_stage.sv - registered immediate generator with a 2-entry skid buffer
module imm_gen_stage #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           flush,
  imm_gen_stage_if.slave bus
);

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  state_t           state;
  state_t           state_nxt;
  logic             in_ready_q;
  logic             out_valid_q;

  // slot0 is always the head of the FIFO; slot1 only holds the younger entry in FULL
  logic [XLEN-1:0]  imm0, imm1;
  logic [TAG_W-1:0] tag0, tag1;
  logic             err0, err1;

  logic [31:0]      imm32;
  logic             sext;
  logic [XLEN-1:0]  dec_imm;
  logic             dec_err;
  logic             accept;
  logic             release_e;

  always_comb begin
    imm32   = 32'd0;
    sext    = 1'b0;
    dec_err = 1'b0;
    case (bus.in_sel)
      4'd0: begin imm32 = {{20{bus.in_inst[31]}}, bus.in_inst[31:20]}; sext = 1'b1; end
      4'd1: begin imm32 = {{20{bus.in_inst[31]}}, bus.in_inst[31:25], bus.in_inst[11:7]}; sext = 1'b1; end
      4'd2: begin
        imm32 = {{19{bus.in_inst[31]}}, bus.in_inst[31], bus.in_inst[7],
                 bus.in_inst[30:25], bus.in_inst[11:8], 1'b0};
        sext  = 1'b1;
      end
      4'd3: begin imm32 = {bus.in_inst[31:12], 12'd0}; sext = 1'b1; end
      4'd4: begin
        imm32 = {{11{bus.in_inst[31]}}, bus.in_inst[31], bus.in_inst[19:12],
                 bus.in_inst[20], bus.in_inst[30:21], 1'b0};
        sext  = 1'b1;
      end
      4'd5: imm32 = {27'd0, bus.in_inst[19:15]};
      4'd6: imm32 = {29'd0, bus.in_inst[22:20]};
      4'd7: imm32 = {28'd0, bus.in_inst[23:20]};
      4'd8: imm32 = {27'd0, bus.in_inst[24:20]};
      4'd9: begin
        // a 6-bit shift amount is meaningless on RV32, so flag it and fall back to 5 bits
        if (XLEN == 32) begin
          imm32   = {27'd0, bus.in_inst[24:20]};
          dec_err = 1'b1;
        end else begin
          imm32   = {26'd0, bus.in_inst[25:20]};
        end
      end
      default: dec_err = 1'b1;
    endcase
    dec_imm = sext ? XLEN'($signed(imm32)) : XLEN'(imm32);
  end

  assign accept    = bus.in_valid && in_ready_q;
  assign release_e = out_valid_q && bus.out_ready;

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY:   if (accept) state_nxt = ONE;
        ONE: begin
          if (accept && !release_e)      state_nxt = FULL;
          else if (release_e && !accept) state_nxt = EMPTY;
        end
        FULL:    if (release_e) state_nxt = ONE;
        default: state_nxt = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= EMPTY;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      imm0        <= '0;
      imm1        <= '0;
      tag0        <= '0;
      tag1        <= '0;
      err0        <= 1'b0;
      err1        <= 1'b0;
    end else begin
      state       <= state_nxt;
      in_ready_q  <= (state_nxt != FULL);
      out_valid_q <= (state_nxt != EMPTY);
      if (!flush) begin
        case (state)
          EMPTY: if (accept) begin
            imm0 <= dec_imm; tag0 <= bus.in_tag; err0 <= dec_err;
          end
          ONE: begin
            if (accept && release_e) begin
              imm0 <= dec_imm; tag0 <= bus.in_tag; err0 <= dec_err;
            end else if (accept) begin
              imm1 <= dec_imm; tag1 <= bus.in_tag; err1 <= dec_err;
            end
          end
          FULL: if (release_e) begin
            imm0 <= imm1; tag0 <= tag1; err0 <= err1;
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_imm   = imm0;
  assign bus.out_tag   = tag0;
  assign bus.out_err   = err0;

endmodule

// File: tb/tb_imm_gen_stage.sv
// tb/tb_imm_gen_stage.sv - directed self-checking bench for imm_gen_stage (XLEN 32 and 64)
module tb_imm_gen_stage;

  localparam int TAG_W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  imm_gen_stage_if #(.XLEN(32), .TAG_W(TAG_W)) b32 ();
  imm_gen_stage_if #(.XLEN(64), .TAG_W(TAG_W)) b64 ();

  // the 64-bit instance sees the same stimulus as the 32-bit one
  assign b64.in_valid  = b32.in_valid;
  assign b64.in_inst   = b32.in_inst;
  assign b64.in_sel    = b32.in_sel;
  assign b64.in_tag    = b32.in_tag;
  assign b64.out_ready = b32.out_ready;

  imm_gen_stage #(.XLEN(32), .TAG_W(TAG_W)) dut32 (
    .clk(clk), .rst(rst), .flush(flush), .bus(b32.slave)
  );

  imm_gen_stage #(.XLEN(64), .TAG_W(TAG_W)) dut64 (
    .clk(clk), .rst(rst), .flush(flush), .bus(b64.slave)
  );

  a_in_hold: assert property (@(posedge clk) disable iff (rst)
    (b32.in_valid && !b32.in_ready && !flush) |=>
      (b32.in_valid && $stable(b32.in_tag) && $stable(b32.in_inst) && $stable(b32.in_sel)))
    else $error("FAIL in_hold: in_valid dropped or payload changed before accept");

  task automatic expect_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] inst, input logic [3:0] sel,
                       input logic [TAG_W-1:0] tag);
    @(negedge clk);
    b32.in_valid = v;
    b32.in_inst  = inst;
    b32.in_sel   = sel;
    b32.in_tag   = tag;
  endtask

  task automatic push_check(input string name, input logic [31:0] inst, input logic [3:0] sel,
                            input logic [TAG_W-1:0] tag,
                            input logic [63:0] e32, input logic e32_err,
                            input logic [63:0] e64, input logic e64_err);
    drive(1'b1, inst, sel, tag);
    b32.out_ready = 1'b1;
    tick();
    b32.in_valid = 1'b0;
    expect_eq({name, "_valid"}, 64'(b32.out_valid), 64'd1);
    expect_eq({name, "_imm32"}, 64'(b32.out_imm), e32);
    expect_eq({name, "_err32"}, 64'(b32.out_err), 64'(e32_err));
    expect_eq({name, "_tag"}, 64'(b32.out_tag), 64'(tag));
    expect_eq({name, "_imm64"}, b64.out_imm, e64);
    expect_eq({name, "_err64"}, 64'(b64.out_err), 64'(e64_err));
  endtask

  initial begin
    b32.in_valid  = 1'b0;
    b32.in_inst   = 32'd0;
    b32.in_sel    = 4'd0;
    b32.in_tag    = '0;
    b32.out_ready = 1'b1;

    #12;
    expect_eq("rst_valid", 64'(b32.out_valid), 64'd0);
    expect_eq("rst_imm", 64'(b32.out_imm), 64'd0);
    expect_eq("rst_tag", 64'(b32.out_tag), 64'd0);
    expect_eq("rst_err", 64'(b32.out_err), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    expect_eq("rst_in_ready", 64'(b32.in_ready), 64'd1);

    push_check("i_neg1", 32'hFFF00093, 4'd0, 8'h11, 64'hFFFFFFFF, 1'b0, 64'hFFFFFFFFFFFFFFFF, 1'b0);
    push_check("s_neg4", 32'hFE112E23, 4'd1, 8'h12, 64'hFFFFFFFC, 1'b0, 64'hFFFFFFFFFFFFFFFC, 1'b0);
    push_check("b_neg4", 32'hFE000EE3, 4'd2, 8'h13, 64'hFFFFFFFC, 1'b0, 64'hFFFFFFFFFFFFFFFC, 1'b0);
    push_check("u_pos", 32'h123450B7, 4'd3, 8'h14, 64'h12345000, 1'b0, 64'h0000000012345000, 1'b0);
    push_check("u_neg", 32'h800000B7, 4'd3, 8'h15, 64'h80000000, 1'b0, 64'hFFFFFFFF80000000, 1'b0);
    push_check("j_8", 32'h008000EF, 4'd4, 8'h16, 64'h8, 1'b0, 64'h8, 1'b0);
    push_check("z_ones", 32'hFFFFFFFF, 4'd5, 8'h17, 64'h1F, 1'b0, 64'h1F, 1'b0);
    push_check("p3_ones", 32'hFFFFFFFF, 4'd6, 8'h18, 64'h7, 1'b0, 64'h7, 1'b0);
    push_check("p4_ones", 32'hFFFFFFFF, 4'd7, 8'h19, 64'hF, 1'b0, 64'hF, 1'b0);
    push_check("p5", 32'h02A05013, 4'd8, 8'h1A, 64'h0A, 1'b0, 64'h0A, 1'b0);
    push_check("p6", 32'h02A05013, 4'd9, 8'h1B, 64'h0A, 1'b1, 64'h2A, 1'b0);
    push_check("sel12", 32'hFFFFFFFF, 4'd12, 8'h1C, 64'h0, 1'b1, 64'h0, 1'b1);
    push_check("sel15", 32'hFFFFFFFF, 4'd15, 8'h1D, 64'h0, 1'b1, 64'h0, 1'b1);
    tick();
    expect_eq("drain_valid", 64'(b32.out_valid), 64'd0);

    // backpressure: third entry must stall until the head drains
    b32.out_ready = 1'b0;
    drive(1'b1, 32'hFFF00093, 4'd0, 8'd1);
    tick();
    expect_eq("bp_in_ready_one", 64'(b32.in_ready), 64'd1);
    drive(1'b1, 32'hFFF00093, 4'd0, 8'd2);
    tick();
    expect_eq("bp_in_ready_full", 64'(b32.in_ready), 64'd0);
    expect_eq("bp_head1", 64'(b32.out_tag), 64'd1);
    drive(1'b1, 32'hFFF00093, 4'd0, 8'd3);
    tick();
    expect_eq("bp_stall_ready", 64'(b32.in_ready), 64'd0);
    expect_eq("bp_stall_head", 64'(b32.out_tag), 64'd1);
    @(negedge clk);
    b32.out_ready = 1'b1;
    tick();
    expect_eq("bp_out2_valid", 64'(b32.out_valid), 64'd1);
    expect_eq("bp_out2", 64'(b32.out_tag), 64'd2);
    expect_eq("bp_ready_after", 64'(b32.in_ready), 64'd1);
    tick();
    b32.in_valid = 1'b0;
    expect_eq("bp_out3_valid", 64'(b32.out_valid), 64'd1);
    expect_eq("bp_out3", 64'(b32.out_tag), 64'd3);
    tick();
    expect_eq("bp_empty", 64'(b32.out_valid), 64'd0);

    // flush from FULL with a live input entry
    b32.out_ready = 1'b0;
    drive(1'b1, 32'hFFF00093, 4'd0, 8'd4);
    tick();
    drive(1'b1, 32'hFFF00093, 4'd0, 8'd5);
    tick();
    expect_eq("fl_full", 64'(b32.in_ready), 64'd0);
    drive(1'b1, 32'h123450B7, 4'd3, 8'd7);
    flush = 1'b1;
    tick();
    expect_eq("fl_valid", 64'(b32.out_valid), 64'd0);
    expect_eq("fl_ready", 64'(b32.in_ready), 64'd1);
    @(negedge clk);
    flush = 1'b0;
    b32.in_valid = 1'b0;
    b32.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_eq("fl_no_tag7", 64'(b32.out_valid), 64'd0);
    end

    // async reset with two entries held
    b32.out_ready = 1'b0;
    drive(1'b1, 32'hFFF00093, 4'd0, 8'd8);
    tick();
    drive(1'b1, 32'hFFF00093, 4'd0, 8'd9);
    tick();
    b32.in_valid = 1'b0;
    expect_eq("ar_pre_imm", 64'(b32.out_imm), 64'hFFFFFFFF);
    #2;
    rst = 1'b1;
    #1;
    expect_eq("ar_valid", 64'(b32.out_valid), 64'd0);
    expect_eq("ar_imm32", 64'(b32.out_imm), 64'd0);
    expect_eq("ar_imm64", b64.out_imm, 64'd0);
    expect_eq("ar_tag", 64'(b32.out_tag), 64'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    tick();
    expect_eq("ar_in_ready", 64'(b32.in_ready), 64'd1);
    expect_eq("ar_post_valid", 64'(b32.out_valid), 64'd0);
    push_check("ar_fresh", 32'hFFF00093, 4'd0, 8'd10, 64'hFFFFFFFF, 1'b0, 64'hFFFFFFFFFFFFFFFF, 1'b0);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
